lsu_arbiter: RTL and testbench
==============================

LSU_ARBITER -- requirements
Module: lsu_arbiter

Interface
REQ-001 clk  in  1  single clock; all state updates on its rising edge.
REQ-002 a_rst  in  1  asynchronous, active-high reset.
REQ-003 sq_start, sq_cmd, sq_width, sq_tag  in  1 each  scheduler request: valid, cmd (1=store, 0=load), width (1=16-bit, 0=8-bit), station tag.
REQ-004 sq_adr, sq_wdata  in  16 each  scheduler address (from AGU) and store data.
REQ-005 sq_wait  out  1  scheduler request not accepted this cycle; hold all sq_* stable.
REQ-006 rmw_start, rmw_cmd, rmw_width  in  1 each; rmw_adr, rmw_wdata  in  16 each  RMW-unit request, same encoding as scheduler.
REQ-007 rmw_wait  out  1  RMW request not accepted this cycle.
REQ-008 mem_adr  out  16; mem_rd, mem_wr  out  1; mem_dout  out  8; mem_din  in  8; mem_ready  in  1  8-bit memory bus.
REQ-009 lsu_data_in  out  16; lsu_data_tag  out  2; lsu_data_wb  out  1  load-return port (tag[1]=source, 0=scheduler/1=RMW; tag[0]=sq_tag, 0 for RMW).

Function
REQ-010 FSM states: IDLE, LO, HI, WB; one request in flight at a time.
REQ-011 Acceptance: a request is accepted at a rising edge where its start=1 and its wait=0; fields are latched into a hold register (cmd, width, adr, wdata, 2-bit tag) at that edge.
REQ-012 sq_wait = sq_start & ~(state==IDLE & grant_sq); rmw_wait = rmw_start & ~(state==IDLE & grant_rmw); wait is 0 when start is 0.
REQ-013 Grant in IDLE: a single requester is granted; with both requesting, the one not granted last wins (round-robin via 1-bit last_grant register, updated on every acceptance).
REQ-014 Acceptance moves IDLE->LO; no acceptance keeps IDLE.
REQ-015 LO: mem_adr=hold.adr, mem_rd=~cmd, mem_wr=cmd, mem_dout=wdata[7:0]; beat completes at an edge with mem_ready=1; mem_ready=0 holds LO with bus outputs stable indefinitely.
REQ-016 LO on completion: load latches mem_din into data[7:0]; width=1 -> HI; width=0 load -> WB; width=0 store -> IDLE.
REQ-017 HI: mem_adr=hold.adr+1 modulo 2^16 (0xFFFF wraps to 0x0000), mem_dout=wdata[15:8], rd/wr as LO; on mem_ready load latches data[15:8] -> WB, store -> IDLE.
REQ-018 8-bit loads zero-extend: data[15:8]=0x00.
REQ-019 WB: exactly one cycle, lsu_data_wb=1, lsu_data_in=assembled data, lsu_data_tag=hold tag; then IDLE. Stores never assert lsu_data_wb.
REQ-020 mem_rd, mem_wr, lsu_data_wb are 0 in IDLE; mem_rd and mem_wr are never 1 simultaneously.
REQ-021 No acceptance outside IDLE: a new request is accepted no earlier than the cycle the FSM returns to IDLE (minimum 2 cycles per 8-bit store, 3 per 8-bit load, 4 per 16-bit load at zero wait states).
REQ-022 In all states other than IDLE both sq_wait and rmw_wait equal their start inputs.

Reset
REQ-023 a_rst asserted: state=IDLE, last_grant=1 (scheduler wins first tie), hold register and data cleared, mem_adr=0, mem_dout=0, mem_rd=mem_wr=lsu_data_wb=0, lsu_data_in=0, lsu_data_tag=0, immediately without waiting for clk.
REQ-024 Reset mid-transfer aborts the access; no writeback is produced for it; requests pending at reset release are arbitrated afresh.

Verification
REQ-025 Scheduler 16-bit load, adr=0x1234, tag=1, mem_ready=1, mem_din 0xCD then 0xAB -> mem_adr 0x1234 then 0x1235, WB cycle with lsu_data_in=0xABCD, lsu_data_tag=2'b01.
REQ-026 Both request simultaneously after reset (sq 8-bit store 0x55 @0x0010, rmw 8-bit load @0x0020) -> sq granted first (rmw_wait=1), mem_wr with dout 0x55; rmw then granted, WB tag=2'b10.
REQ-027 RMW 16-bit store adr=0xFFFF wdata=0xBEEF -> beats at 0xFFFF (0xEF) and 0x0000 (0xBE), no lsu_data_wb.
REQ-028 8-bit load with mem_ready low 3 cycles -> LO held 4 cycles with stable mem_adr/mem_rd; lsu_data_in=0x00xx upon WB.
REQ-029 a_rst asserted during HI of a 16-bit load -> mem_rd=0 immediately, no WB pulse, next request after release completes normally.
REQ-030 Continuous requests from both sources for 8 transfers -> grants strictly alternate.

Source files
------------

// File: rtl/lsu_arbiter.sv
// ---------------------------------------------------------------------------
// lsu_arbiter
//
// Purpose:
//   Shares one 8-bit memory bus between the instruction scheduler and the
//   read-modify-write (RMW) unit. One request is in flight at a time. Each
//   request is an 8-bit or 16-bit load or store. A 16-bit access is split
//   into two byte beats: the low byte at adr, then the high byte at adr+1.
//   Loads return their data through a one-cycle writeback pulse. The tag on
//   that pulse tells the caller which requester and station the data is for.
//
// Ports:
//   clk, a_rst            clock (rising edge), asynchronous active-high reset
//   sq_*                  scheduler request (start/cmd/width/tag/adr/wdata)
//   sq_wait               scheduler request not taken this cycle
//   rmw_*                 RMW-unit request (start/cmd/width/adr/wdata)
//   rmw_wait              RMW request not taken this cycle
//   mem_adr/rd/wr/dout    byte-wide memory bus outputs
//   mem_din, mem_ready    byte-wide memory bus inputs
//   lsu_data_in/tag/wb    load writeback (tag[1]=source, tag[0]=station tag)
// ---------------------------------------------------------------------------
module lsu_arbiter (
  input  logic        clk,
  input  logic        a_rst,
  input  logic        sq_start,
  input  logic        sq_cmd,
  input  logic        sq_width,
  input  logic        sq_tag,
  input  logic [15:0] sq_adr,
  input  logic [15:0] sq_wdata,
  output logic        sq_wait,
  input  logic        rmw_start,
  input  logic        rmw_cmd,
  input  logic        rmw_width,
  input  logic [15:0] rmw_adr,
  input  logic [15:0] rmw_wdata,
  output logic        rmw_wait,
  output logic [15:0] mem_adr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_dout,
  input  logic [7:0]  mem_din,
  input  logic        mem_ready,
  output logic [15:0] lsu_data_in,
  output logic [1:0]  lsu_data_tag,
  output logic        lsu_data_wb
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        hold_cmd_q, hold_cmd_d;
  logic        hold_width_q, hold_width_d;
  logic [15:0] hold_adr_q, hold_adr_d;
  logic [7:0]  hold_wdata_hi_q, hold_wdata_hi_d;
  logic [1:0]  hold_tag_q, hold_tag_d;
  logic [7:0]  data_lo_q, data_lo_d;
  logic [15:0] mem_adr_q, mem_adr_d;
  logic        mem_rd_q, mem_rd_d;
  logic        mem_wr_q, mem_wr_d;
  logic [7:0]  mem_dout_q, mem_dout_d;
  logic [15:0] lsu_data_in_q, lsu_data_in_d;
  logic [1:0]  lsu_data_tag_q, lsu_data_tag_d;
  logic        lsu_data_wb_q, lsu_data_wb_d;

  logic        is_idle;
  logic        grant_sq;
  logic        grant_rmw;
  logic        accept;
  logic        sel_cmd;
  logic        sel_width;
  logic [15:0] sel_adr;
  logic [15:0] sel_wdata;
  logic [1:0]  sel_tag;

  // last_grant_q = 1 means the RMW unit won the previous grant. On a tie,
  // the scheduler therefore wins whenever last_grant_q is set.
  assign is_idle   = (state_q == ST_IDLE);
  assign grant_sq  = sq_start & (~rmw_start | last_grant_q);
  assign grant_rmw = rmw_start & ~grant_sq;
  assign accept    = is_idle & (grant_sq | grant_rmw);

  assign sq_wait   = sq_start  & ~(is_idle & grant_sq);
  assign rmw_wait  = rmw_start & ~(is_idle & grant_rmw);

  assign sel_cmd   = grant_sq ? sq_cmd   : rmw_cmd;
  assign sel_width = grant_sq ? sq_width : rmw_width;
  assign sel_adr   = grant_sq ? sq_adr   : rmw_adr;
  assign sel_wdata = grant_sq ? sq_wdata : rmw_wdata;
  assign sel_tag   = grant_sq ? {1'b0, sq_tag} : 2'b10;

  // Next-state logic. Bus outputs are computed one edge early so that they
  // come straight from flops and are valid for the whole state they belong to.
  // The low data byte never needs holding, so its flop is not kept: mem_dout
  // is loaded at acceptance and only the high byte is saved for the HI beat.
  always_comb begin
    state_d         = state_q;
    last_grant_d    = last_grant_q;
    hold_cmd_d      = hold_cmd_q;
    hold_width_d    = hold_width_q;
    hold_adr_d      = hold_adr_q;
    hold_wdata_hi_d = hold_wdata_hi_q;
    hold_tag_d      = hold_tag_q;
    data_lo_d       = data_lo_q;
    mem_adr_d       = mem_adr_q;
    mem_rd_d        = mem_rd_q;
    mem_wr_d        = mem_wr_q;
    mem_dout_d      = mem_dout_q;
    lsu_data_in_d   = lsu_data_in_q;
    lsu_data_tag_d  = lsu_data_tag_q;
    lsu_data_wb_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mem_rd_d = 1'b0;
        mem_wr_d = 1'b0;
        if (accept) begin
          state_d         = ST_LO;
          last_grant_d    = grant_rmw;
          hold_cmd_d      = sel_cmd;
          hold_width_d    = sel_width;
          hold_adr_d      = sel_adr;
          hold_wdata_hi_d = sel_wdata[15:8];
          hold_tag_d      = sel_tag;
          mem_adr_d       = sel_adr;
          mem_rd_d        = ~sel_cmd;
          mem_wr_d        = sel_cmd;
          mem_dout_d      = sel_wdata[7:0];
        end
      end

      ST_LO: begin
        if (mem_ready) begin
          if (!hold_cmd_q) begin
            data_lo_d = mem_din;
          end
          if (hold_width_q) begin
            // The address wraps from 0xFFFF to 0x0000 through 16-bit overflow.
            state_d    = ST_HI;
            mem_adr_d  = hold_adr_q + 16'd1;
            mem_dout_d = hold_wdata_hi_q;
          end else if (!hold_cmd_q) begin
            state_d        = ST_WB;
            mem_rd_d       = 1'b0;
            lsu_data_wb_d  = 1'b1;
            lsu_data_in_d  = {8'h00, mem_din};
            lsu_data_tag_d = hold_tag_q;
          end else begin
            state_d  = ST_IDLE;
            mem_wr_d = 1'b0;
          end
        end
      end

      ST_HI: begin
        if (mem_ready) begin
          mem_rd_d = 1'b0;
          mem_wr_d = 1'b0;
          if (!hold_cmd_q) begin
            state_d        = ST_WB;
            lsu_data_wb_d  = 1'b1;
            lsu_data_in_d  = {mem_din, data_lo_q};
            lsu_data_tag_d = hold_tag_q;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_WB: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state and registered outputs. Reset clears the bus and the writeback
  // port at once, which aborts any access in flight without a writeback.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state_q         <= ST_IDLE;
      last_grant_q    <= 1'b1;
      hold_cmd_q      <= 1'b0;
      hold_width_q    <= 1'b0;
      hold_adr_q      <= 16'h0000;
      hold_wdata_hi_q <= 8'h00;
      hold_tag_q      <= 2'b00;
      data_lo_q       <= 8'h00;
      mem_adr_q       <= 16'h0000;
      mem_rd_q        <= 1'b0;
      mem_wr_q        <= 1'b0;
      mem_dout_q      <= 8'h00;
      lsu_data_in_q   <= 16'h0000;
      lsu_data_tag_q  <= 2'b00;
      lsu_data_wb_q   <= 1'b0;
    end else begin
      state_q         <= state_d;
      last_grant_q    <= last_grant_d;
      hold_cmd_q      <= hold_cmd_d;
      hold_width_q    <= hold_width_d;
      hold_adr_q      <= hold_adr_d;
      hold_wdata_hi_q <= hold_wdata_hi_d;
      hold_tag_q      <= hold_tag_d;
      data_lo_q       <= data_lo_d;
      mem_adr_q       <= mem_adr_d;
      mem_rd_q        <= mem_rd_d;
      mem_wr_q        <= mem_wr_d;
      mem_dout_q      <= mem_dout_d;
      lsu_data_in_q   <= lsu_data_in_d;
      lsu_data_tag_q  <= lsu_data_tag_d;
      lsu_data_wb_q   <= lsu_data_wb_d;
    end
  end

  assign mem_adr      = mem_adr_q;
  assign mem_rd       = mem_rd_q;
  assign mem_wr       = mem_wr_q;
  assign mem_dout     = mem_dout_q;
  assign lsu_data_in  = lsu_data_in_q;
  assign lsu_data_tag = lsu_data_tag_q;
  assign lsu_data_wb  = lsu_data_wb_q;

endmodule

// File: tb/tb_lsu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_lsu_arbiter
//
// Purpose:
//   Self-checking bench for lsu_arbiter. A transaction-level model follows the
//   request in flight as a record with a beat index. A compare process checks
//   the DUT against that model on every negative clock edge. Directed
//   sequences pin the model with hand-computed values, and randomized traffic
//   from both requesters exercises arbitration, wait states and wraparound.
// ---------------------------------------------------------------------------
module tb_lsu_arbiter;

  logic        clk;
  logic        a_rst;
  logic        sq_start, sq_cmd, sq_width, sq_tag;
  logic [15:0] sq_adr, sq_wdata;
  logic        sq_wait;
  logic        rmw_start, rmw_cmd, rmw_width;
  logic [15:0] rmw_adr, rmw_wdata;
  logic        rmw_wait;
  logic [15:0] mem_adr;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_dout;
  logic [7:0]  mem_din;
  logic        mem_ready;
  logic [15:0] lsu_data_in;
  logic [1:0]  lsu_data_tag;
  logic        lsu_data_wb;

  int vec_count = 0;
  int err_count = 0;
  int acc_log[$];

  lsu_arbiter dut (
    .clk          (clk),
    .a_rst        (a_rst),
    .sq_start     (sq_start),
    .sq_cmd       (sq_cmd),
    .sq_width     (sq_width),
    .sq_tag       (sq_tag),
    .sq_adr       (sq_adr),
    .sq_wdata     (sq_wdata),
    .sq_wait      (sq_wait),
    .rmw_start    (rmw_start),
    .rmw_cmd      (rmw_cmd),
    .rmw_width    (rmw_width),
    .rmw_adr      (rmw_adr),
    .rmw_wdata    (rmw_wdata),
    .rmw_wait     (rmw_wait),
    .mem_adr      (mem_adr),
    .mem_rd       (mem_rd),
    .mem_wr       (mem_wr),
    .mem_dout     (mem_dout),
    .mem_din      (mem_din),
    .mem_ready    (mem_ready),
    .lsu_data_in  (lsu_data_in),
    .lsu_data_tag (lsu_data_tag),
    .lsu_data_wb  (lsu_data_wb)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net: should never trigger, keeps the run from hanging.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // One comparison. Every checked value in the bench goes through here.
  task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
    vec_count++;
    if (act !== exp) begin
      err_count++;
      $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Drive the memory response for this cycle, then move to just after the
  // next rising edge.
  task automatic applyStimulus(input logic rdy, input logic [7:0] din);
    mem_ready = rdy;
    mem_din   = din;
    @(posedge clk);
    #1;
  endtask

  // ------------------------------------------------------------------------
  // Reference model: the request in flight plus which byte beat it is on.
  // m_last = 1 means the RMW unit was granted most recently.
  // ------------------------------------------------------------------------
  logic        m_busy, m_wb, m_beat, m_last;
  logic        m_cmd, m_width;
  logic [15:0] m_adr, m_wdata, m_data;
  logic [1:0]  m_tag;

  // Who gets the bus if the arbiter is idle: -1 none, 0 scheduler, 1 RMW.
  function automatic int pick();
    if (sq_start && rmw_start) return m_last ? 0 : 1;
    if (sq_start) return 0;
    if (rmw_start) return 1;
    return -1;
  endfunction

  // Advance the model at each rising edge. Reset drops the request in flight.
  always @(posedge clk or posedge a_rst) begin
    int p;
    if (a_rst) begin
      m_busy <= 1'b0;
      m_wb   <= 1'b0;
      m_beat <= 1'b0;
      m_last <= 1'b1;
      m_data <= 16'h0000;
    end else if (m_wb) begin
      m_wb <= 1'b0;
    end else if (m_busy) begin
      if (mem_ready) begin
        if (!m_cmd) begin
          if (m_beat) m_data[15:8] <= mem_din;
          else        m_data[7:0]  <= mem_din;
        end
        if (!m_beat && m_width) begin
          m_beat <= 1'b1;
        end else begin
          m_busy <= 1'b0;
          m_wb   <= !m_cmd;
        end
      end
    end else begin
      p = pick();
      if (p >= 0) begin
        m_busy  <= 1'b1;
        m_beat  <= 1'b0;
        m_data  <= 16'h0000;
        m_last  <= (p == 1);
        m_cmd   <= (p == 0) ? sq_cmd   : rmw_cmd;
        m_width <= (p == 0) ? sq_width : rmw_width;
        m_adr   <= (p == 0) ? sq_adr   : rmw_adr;
        m_wdata <= (p == 0) ? sq_wdata : rmw_wdata;
        m_tag   <= (p == 0) ? {1'b0, sq_tag} : 2'b10;
      end
    end
  end

  // Compare process. It runs on the falling edge, midway between rising
  // edges, so registered outputs and the combinational waits are both settled.
  always @(negedge clk) begin
    logic idle;
    int   p;
    if (!a_rst) begin
      idle = !m_busy && !m_wb;
      p    = pick();
      checkOutput("sq_wait",  {15'd0, sq_wait},  {15'd0, sq_start  && !(idle && p == 0)});
      checkOutput("rmw_wait", {15'd0, rmw_wait}, {15'd0, rmw_start && !(idle && p == 1)});
      checkOutput("mem_rd", {15'd0, mem_rd}, {15'd0, m_busy && !m_cmd});
      checkOutput("mem_wr", {15'd0, mem_wr}, {15'd0, m_busy &&  m_cmd});
      checkOutput("lsu_data_wb", {15'd0, lsu_data_wb}, {15'd0, m_wb});
      if (m_busy) begin
        checkOutput("mem_adr", mem_adr, m_adr + {15'd0, m_beat});
        checkOutput("mem_dout", {8'd0, mem_dout}, {8'd0, m_beat ? m_wdata[15:8] : m_wdata[7:0]});
      end
      if (m_wb) begin
        checkOutput("lsu_data_in", lsu_data_in, m_data);
        checkOutput("lsu_data_tag", {14'd0, lsu_data_tag}, {14'd0, m_tag});
      end
    end
  end

  // ------------------------------------------------------------------------
  // Random request generators
  // ------------------------------------------------------------------------
  task automatic newSq(input bit saturate);
    sq_start = 1'b1;
    sq_cmd   = saturate ? 1'b1 : 1'($urandom);
    sq_width = saturate ? 1'b0 : 1'($urandom);
    sq_tag   = 1'($urandom);
    sq_adr   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
    sq_wdata = 16'($urandom);
  endtask

  task automatic newRmw(input bit saturate);
    rmw_start = 1'b1;
    rmw_cmd   = saturate ? 1'b1 : 1'($urandom);
    rmw_width = saturate ? 1'b0 : 1'($urandom);
    rmw_adr   = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
    rmw_wdata = 16'($urandom);
  endtask

  // Traffic from both sides. A request is held until the DUT takes it. In
  // saturate mode both sides request continuously with 8-bit stores.
  task automatic runTraffic(input int cycles, input bit saturate);
    logic sq_acc, rmw_acc;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      sq_acc  = sq_start  && !sq_wait;
      rmw_acc = rmw_start && !rmw_wait;
      if (sq_acc)  acc_log.push_back(0);
      if (rmw_acc) acc_log.push_back(1);
      @(posedge clk);
      #1;
      if (!sq_start || sq_acc) begin
        if (saturate || $urandom_range(0, 2) == 0) newSq(saturate);
        else sq_start = 1'b0;
      end
      if (!rmw_start || rmw_acc) begin
        if (saturate || $urandom_range(0, 2) == 0) newRmw(saturate);
        else rmw_start = 1'b0;
      end
      mem_ready = saturate ? 1'b1 : ($urandom_range(0, 3) != 0);
      mem_din   = 8'($urandom);
    end
  endtask

  task automatic drain();
    sq_start  = 1'b0;
    rmw_start = 1'b0;
    repeat (6) applyStimulus(1'b1, 8'h00);
  endtask

  // ------------------------------------------------------------------------
  // Main sequence
  // ------------------------------------------------------------------------
  initial begin
    a_rst = 1'b1;
    sq_start = 1'b0; sq_cmd = 1'b0; sq_width = 1'b0; sq_tag = 1'b0;
    sq_adr = 16'h0000; sq_wdata = 16'h0000;
    rmw_start = 1'b0; rmw_cmd = 1'b0; rmw_width = 1'b0;
    rmw_adr = 16'h0000; rmw_wdata = 16'h0000;
    mem_din = 8'h00; mem_ready = 1'b0;

    // Reset values
    #12;
    checkOutput("rst_mem_adr", mem_adr, 16'h0000);
    checkOutput("rst_mem_rd", {15'd0, mem_rd}, 16'd0);
    checkOutput("rst_mem_wr", {15'd0, mem_wr}, 16'd0);
    checkOutput("rst_mem_dout", {8'd0, mem_dout}, 16'd0);
    checkOutput("rst_wb", {15'd0, lsu_data_wb}, 16'd0);
    checkOutput("rst_data_in", lsu_data_in, 16'h0000);
    checkOutput("rst_tag", {14'd0, lsu_data_tag}, 16'd0);
    @(posedge clk);
    #1;
    a_rst = 1'b0;

    // Both request at once after reset: the scheduler store wins, then the
    // RMW load, which returns with tag 2'b10.
    sq_start = 1'b1; sq_cmd = 1'b1; sq_width = 1'b0; sq_tag = 1'b0;
    sq_adr = 16'h0010; sq_wdata = 16'h0055;
    rmw_start = 1'b1; rmw_cmd = 1'b0; rmw_width = 1'b0; rmw_adr = 16'h0020;
    #1;
    checkOutput("tie_sq_wait", {15'd0, sq_wait}, 16'd0);
    checkOutput("tie_rmw_wait", {15'd0, rmw_wait}, 16'd1);
    applyStimulus(1'b1, 8'h00);
    sq_start = 1'b0;
    checkOutput("tie_wr", {15'd0, mem_wr}, 16'd1);
    checkOutput("tie_rd", {15'd0, mem_rd}, 16'd0);
    checkOutput("tie_adr", mem_adr, 16'h0010);
    checkOutput("tie_dout", {8'd0, mem_dout}, 16'h0055);
    checkOutput("tie_rmw_wait_busy", {15'd0, rmw_wait}, 16'd1);
    applyStimulus(1'b1, 8'h00);
    checkOutput("tie_store_done", {15'd0, mem_wr}, 16'd0);
    checkOutput("tie_rmw_wait_idle", {15'd0, rmw_wait}, 16'd0);
    applyStimulus(1'b1, 8'h77);
    rmw_start = 1'b0;
    checkOutput("tie_rmw_adr", mem_adr, 16'h0020);
    checkOutput("tie_rmw_rd", {15'd0, mem_rd}, 16'd1);
    applyStimulus(1'b1, 8'h77);
    checkOutput("tie_wb", {15'd0, lsu_data_wb}, 16'd1);
    checkOutput("tie_wb_tag", {14'd0, lsu_data_tag}, 16'b10);
    checkOutput("tie_wb_data", lsu_data_in, 16'h0077);
    applyStimulus(1'b0, 8'h00);
    checkOutput("tie_wb_end", {15'd0, lsu_data_wb}, 16'd0);

    // Scheduler 16-bit load, two beats at 0x1234 / 0x1235.
    sq_start = 1'b1; sq_cmd = 1'b0; sq_width = 1'b1; sq_tag = 1'b1;
    sq_adr = 16'h1234; sq_wdata = 16'h0000;
    applyStimulus(1'b1, 8'h00);
    sq_start = 1'b0;
    checkOutput("ld16_lo_adr", mem_adr, 16'h1234);
    checkOutput("ld16_lo_rd", {15'd0, mem_rd}, 16'd1);
    applyStimulus(1'b1, 8'hCD);
    checkOutput("ld16_hi_adr", mem_adr, 16'h1235);
    checkOutput("ld16_hi_rd", {15'd0, mem_rd}, 16'd1);
    applyStimulus(1'b1, 8'hAB);
    checkOutput("ld16_wb", {15'd0, lsu_data_wb}, 16'd1);
    checkOutput("ld16_data", lsu_data_in, 16'hABCD);
    checkOutput("ld16_tag", {14'd0, lsu_data_tag}, 16'b01);
    applyStimulus(1'b0, 8'h00);

    // RMW 16-bit store across the top of the address space.
    rmw_start = 1'b1; rmw_cmd = 1'b1; rmw_width = 1'b1;
    rmw_adr = 16'hFFFF; rmw_wdata = 16'hBEEF;
    applyStimulus(1'b1, 8'h00);
    rmw_start = 1'b0;
    checkOutput("st16_lo_adr", mem_adr, 16'hFFFF);
    checkOutput("st16_lo_dout", {8'd0, mem_dout}, 16'h00EF);
    checkOutput("st16_lo_wr", {15'd0, mem_wr}, 16'd1);
    applyStimulus(1'b1, 8'h00);
    checkOutput("st16_hi_adr", mem_adr, 16'h0000);
    checkOutput("st16_hi_dout", {8'd0, mem_dout}, 16'h00BE);
    checkOutput("st16_hi_wb", {15'd0, lsu_data_wb}, 16'd0);
    applyStimulus(1'b1, 8'h00);
    checkOutput("st16_done_wr", {15'd0, mem_wr}, 16'd0);
    checkOutput("st16_done_wb", {15'd0, lsu_data_wb}, 16'd0);

    // 8-bit load with three wait states, zero-extended on return.
    sq_start = 1'b1; sq_cmd = 1'b0; sq_width = 1'b0; sq_tag = 1'b0;
    sq_adr = 16'h4242;
    applyStimulus(1'b0, 8'h00);
    sq_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput("ws_adr", mem_adr, 16'h4242);
      checkOutput("ws_rd", {15'd0, mem_rd}, 16'd1);
      applyStimulus(i == 3, 8'h9C);
    end
    checkOutput("ws_wb", {15'd0, lsu_data_wb}, 16'd1);
    checkOutput("ws_data", lsu_data_in, 16'h009C);
    applyStimulus(1'b0, 8'h00);

    // Reset during the high beat of a 16-bit load.
    sq_start = 1'b1; sq_cmd = 1'b0; sq_width = 1'b1; sq_tag = 1'b1;
    sq_adr = 16'h3000;
    applyStimulus(1'b1, 8'h00);
    sq_start = 1'b0;
    applyStimulus(1'b1, 8'h11);
    checkOutput("rmid_hi_rd", {15'd0, mem_rd}, 16'd1);
    mem_ready = 1'b0;
    #2;
    a_rst = 1'b1;
    #1;
    checkOutput("rmid_rd_now", {15'd0, mem_rd}, 16'd0);
    checkOutput("rmid_wb_now", {15'd0, lsu_data_wb}, 16'd0);
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 8'h22);
      checkOutput("rmid_no_wb", {15'd0, lsu_data_wb}, 16'd0);
    end
    sq_start = 1'b1; sq_cmd = 1'b0; sq_width = 1'b0; sq_tag = 1'b1;
    sq_adr = 16'h0005;
    applyStimulus(1'b1, 8'h00);
    sq_start = 1'b0;
    applyStimulus(1'b1, 8'h3C);
    checkOutput("rmid_after_wb", {15'd0, lsu_data_wb}, 16'd1);
    checkOutput("rmid_after_data", lsu_data_in, 16'h003C);
    checkOutput("rmid_after_tag", {14'd0, lsu_data_tag}, 16'b01);
    applyStimulus(1'b0, 8'h00);

    // Continuous traffic from both: grants must alternate. The scheduler
    // was granted last, so the RMW unit goes first.
    acc_log.delete();
    runTraffic(24, 1'b1);
    drain();
    checkOutput("alt_enough_grants", {15'd0, acc_log.size() >= 8}, 16'd1);
    if (acc_log.size() >= 8) begin
      checkOutput("alt_first", 16'(acc_log[0]), 16'd1);
      for (int i = 1; i < 8; i++)
        checkOutput("alt_toggle", 16'(acc_log[i]), 16'(1 - acc_log[i-1]));
    end

    // Randomized traffic, checked by the model every cycle.
    runTraffic(2000, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
